fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port stall  input  1  decode stage cannot accept; hold IF/ID.
REQ-005 SHALL have port branch_taken  input  1  one-cycle redirect pulse from a later stage.
REQ-006 SHALL have port branch_target  input  32  redirect address, sampled with branch_taken.
REQ-007 SHALL have port imem_req  output  1  instruction memory request.
REQ-008 SHALL have port imem_addr  output  32  request address; stable while imem_req=1 and imem_ready=0.
REQ-009 SHALL have ports imem_ready (input, 1) and imem_data (input, 32): response valid this cycle, combinational.
REQ-010 SHALL have ports if_id_instr (output, 32), if_id_pc_plus4 (output, 32) and if_id_valid (output, 1): registered IF/ID contents that feed the decode stage's field split.

Function
REQ-011 SHALL be a 3-state FSM: FETCH (imem_req=1, imem_addr=pc), HOLD (imem_req=0, skid buffer full), DRAIN (imem_req=1, imem_addr=pc held, response discarded).
REQ-012 FETCH, branch_taken and imem_ready: data discarded; pc<=branch_target; stay FETCH.
REQ-013 FETCH, branch_taken and !imem_ready: redirect_pc<=branch_target; go DRAIN.
REQ-014 FETCH, imem_ready and !stall: IF/ID<={imem_data, pc+4, valid=1}; pc<=pc+4.
REQ-015 FETCH, imem_ready and stall: skid<={imem_data, pc+4}; pc<=pc+4; go HOLD.
REQ-016 HOLD: branch_taken drops skid, pc<=branch_target, go FETCH; else !stall moves skid into IF/ID (valid=1), go FETCH; else stay.
REQ-017 DRAIN: branch_taken overwrites redirect_pc (newest wins); on imem_ready pc<=(branch_taken ? branch_target : redirect_pc), go FETCH; data never enters IF/ID.
REQ-018 IF/ID priority: branch_taken > stall > load; branch_taken forces instr=32'h0 (NOP), pc_plus4=0, valid=0.
REQ-019 stall without branch_taken SHALL hold IF/ID unchanged.
REQ-020 No branch, no stall, no load SHALL write a bubble: instr=0, valid=0.
REQ-021 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-022 Load-to-IF/ID latency SHALL be one edge after imem_ready.

Reset
REQ-023 While reset=1: pc=RESET_PC, state=FETCH, imem_req=0, skid cleared, redirect_pc=0, all IF/ID outputs 0.
REQ-024 Reset mid-DRAIN or mid-HOLD SHALL discard pending redirect and skid; first request after release uses RESET_PC.

Configuration
REQ-025 Macro FETCH_PERF_CNT_EN defined: SHALL add outputs perf_fetch_cnt (32) counting IF/ID loads with valid=1 and perf_bubble_cnt (32) counting cycles IF/ID is written with valid=0; both reset to 0, wrap at 2^32.
REQ-026 Macro undefined: SHALL have neither ports nor counter logic.

Structure
REQ-027 Shared package SHALL hold FSM state enum (FETCH, HOLD, DRAIN), NOP constant 32'h0 and instruction width 32.
REQ-028 PC register plus next-PC mux SHALL be a sub-module fetch_pc_gen; FSM, skid and IF/ID stay in fetch_stage.

Verification
REQ-029 Reset release, imem_ready=1 every cycle, no stall -> addresses 0,4,8; if_id_pc_plus4 4,8,12 one edge after each ready.
REQ-030 stall=1 when data 32'h2002_0005 returns at pc 8 -> HOLD, imem_req=0; IF/ID unchanged; stall=0 -> if_id_instr=32'h2002_0005, valid=1, next request addr 12.
REQ-031 branch_taken, branch_target=32'h100 while imem_ready=0 at addr 0x10 -> DRAIN, imem_addr stays 0x10; ready returns -> data dropped; next request 0x100; IF/ID valid=0 meanwhile.
REQ-032 Second branch_taken (target 0x200) in DRAIN -> next request 0x200, not 0x100.
REQ-033 RESET_PC=32'hFFFF_FFFC, ready continuous -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-034 Reset asserted in HOLD -> outputs 0 immediately; after release first request at RESET_PC, skid contents never appear.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BRANCH,
        PC_REDIRECT
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection for the fetch stage.
module fetch_pc_gen
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    // Wraps modulo 2^32 by construction.
    assign o_pc_plus4 = r_pc + 32'd4;
    assign o_pc       = r_pc;

    always_comb begin
        w_pc_next = r_pc;
        case (pc_sel_t'(i_sel))
            PC_HOLD:     w_pc_next = r_pc;
            PC_INC:      w_pc_next = o_pc_plus4;
            PC_BRANCH:   w_pc_next = i_branch_target;
            PC_REDIRECT: w_pc_next = i_redirect_pc;
            default:     w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pc <= RESET_PC;
        else       r_pc <= w_pc_next;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request FSM, one-entry skid buffer and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/bubble performance counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_bubble_cnt
`endif
);

    state_t              r_state;
    state_t              w_state_next;
    pc_sel_t             w_pc_sel;
    logic [31:0]         w_pc;
    logic [31:0]         w_pc_plus4;
    logic [31:0]         r_redirect_pc;
    logic [INSTR_W-1:0]  r_skid_instr;
    logic [31:0]         r_skid_pc4;
    logic                w_skid_we;
    logic                w_redirect_we;
    logic                w_load;
    logic [INSTR_W-1:0]  w_load_instr;
    logic [31:0]         w_load_pc4;
    logic [INSTR_W-1:0]  r_if_instr;
    logic [31:0]         r_if_pc4;
    logic                r_if_valid;

    fetch_pc_gen #(
        .RESET_PC(RESET_PC)
    ) u_pc_gen (
        .clk             (clk),
        .reset           (reset),
        .i_sel           (w_pc_sel),
        .i_branch_target (branch_target),
        .i_redirect_pc   (r_redirect_pc),
        .o_pc            (w_pc),
        .o_pc_plus4      (w_pc_plus4)
    );

    assign imem_req  = !reset && (r_state != HOLD);
    assign imem_addr = w_pc;

    always_comb begin
        w_state_next  = r_state;
        w_pc_sel      = PC_HOLD;
        w_skid_we     = 1'b0;
        w_redirect_we = 1'b0;
        w_load        = 1'b0;
        w_load_instr  = NOP;
        w_load_pc4    = '0;
        case (r_state)
            FETCH: begin
                if (branch_taken) begin
                    if (imem_ready) begin
                        w_pc_sel = PC_BRANCH;
                    end else begin
                        w_redirect_we = 1'b1;
                        w_state_next  = DRAIN;
                    end
                end else if (imem_ready) begin
                    w_pc_sel = PC_INC;
                    if (stall) begin
                        w_skid_we    = 1'b1;
                        w_state_next = HOLD;
                    end else begin
                        w_load       = 1'b1;
                        w_load_instr = imem_data;
                        w_load_pc4   = w_pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (branch_taken) begin
                    w_pc_sel     = PC_BRANCH;
                    w_state_next = FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_skid_instr;
                    w_load_pc4   = r_skid_pc4;
                    w_state_next = FETCH;
                end
            end
            DRAIN: begin
                // A branch arriving in the same cycle as the response still wins.
                w_redirect_we = branch_taken;
                if (imem_ready) begin
                    w_pc_sel     = branch_taken ? PC_BRANCH : PC_REDIRECT;
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FETCH;
            r_redirect_pc <= '0;
            r_skid_instr  <= '0;
            r_skid_pc4    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_redirect_we) r_redirect_pc <= branch_target;
            if (w_skid_we) begin
                r_skid_instr <= imem_data;
                r_skid_pc4   <= w_pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_if_instr <= '0;
            r_if_pc4   <= '0;
            r_if_valid <= 1'b0;
        end else if (branch_taken) begin
            r_if_instr <= NOP;
            r_if_pc4   <= '0;
            r_if_valid <= 1'b0;
        end else if (!stall) begin
            r_if_instr <= w_load_instr;
            r_if_pc4   <= w_load_pc4;
            r_if_valid <= w_load;
        end
    end

    assign if_id_instr    = r_if_instr;
    assign if_id_pc_plus4 = r_if_pc4;
    assign if_id_valid    = r_if_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_bubble;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetch  <= '0;
            r_perf_bubble <= '0;
        end else if (branch_taken || (!stall && !w_load)) begin
            r_perf_bubble <= r_perf_bubble + 32'd1;
        end else if (!stall) begin
            r_perf_fetch <= r_perf_fetch + 32'd1;
        end
    end

    assign perf_fetch_cnt  = r_perf_fetch;
    assign perf_bubble_cnt = r_perf_bubble;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: queued expected request addresses and IF/ID loads.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_ready;
    logic [31:0] imem_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    logic        w2_req;
    logic [31:0] w2_addr;
    logic [31:0] w2_instr;
    logic [31:0] w2_pc4;
    logic        w2_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt, perf2_fetch, perf2_bubble;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_pc4[$];

    fetch_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    fetch_stage #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_req       (w2_req),
        .imem_addr      (w2_addr),
        .imem_ready     (imem_ready),
        .imem_data      (imem_data),
        .if_id_instr    (w2_instr),
        .if_id_pc_plus4 (w2_pc4),
        .if_id_valid    (w2_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf2_fetch),
        .perf_bubble_cnt(perf2_bubble)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h8) return 32'h2002_0005;
        return {16'hC0DE, a[15:0]};
    endfunction

    assign imem_data = mem(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic push_addr(input logic [31:0] a);
        exp_addr.push_back(a);
    endtask

    task automatic push_load(input logic [31:0] i, input logic [31:0] p);
        exp_instr.push_back(i);
        exp_pc4.push_back(p);
    endtask

    // Monitor: sample just before each rising edge, check IF/ID just after it.
    initial begin
        logic s_rst, s_stall;
        forever begin
            @(negedge clk);
            #4;
            s_rst   = reset;
            s_stall = stall;
            if (!s_rst && imem_req && imem_ready) begin
                if (exp_addr.size() == 0) chk("unexpected_req", imem_addr, 32'hDEAD_DEAD);
                else chk("req_addr", imem_addr, exp_addr.pop_front());
            end
            @(posedge clk);
            #1;
            if (!s_rst && !s_stall && if_id_valid) begin
                if (exp_instr.size() == 0) begin
                    chk("unexpected_load", if_id_instr, 32'hDEAD_DEAD);
                end else begin
                    chk("load_instr", if_id_instr, exp_instr.pop_front());
                    chk("load_pc4", if_id_pc_plus4, exp_pc4.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0;
        branch_target = '0; imem_ready = 1'b0;
        repeat (2) cyc();
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_instr", if_id_instr, 32'h0);
        chk("rst_pc4", if_id_pc_plus4, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("wrap_rst_addr", w2_addr, 32'hFFFF_FFFC);

        // Sequential fetch from address 0.
        imem_ready = 1'b1;
        push_addr(32'h0); push_load(32'hC0DE_0000, 32'h4);
        push_addr(32'h4); push_load(32'hC0DE_0004, 32'h8);
        reset = 1'b0;
        chk("wrap_req", {31'b0, w2_req}, 32'h1);
        cyc();
        chk("wrap_addr2", w2_addr, 32'h0);
        chk("wrap_pc4", w2_pc4, 32'h0);
        chk("addr_after1", imem_addr, 32'h4);
        cyc();

        // Stall when data returns at pc 8.
        stall = 1'b1;
        push_addr(32'h8);
        cyc();
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_instr", if_id_instr, 32'hC0DE_0004);
        cyc();
        chk("hold2_instr", if_id_instr, 32'hC0DE_0004);
        chk("hold2_pc4", if_id_pc_plus4, 32'h8);
        stall = 1'b0;
        push_load(32'h2002_0005, 32'hC);
        cyc();
        chk("after_hold_req", {31'b0, imem_req}, 32'h1);
        chk("after_hold_addr", imem_addr, 32'hC);
        push_addr(32'hC); push_load(32'hC0DE_000C, 32'h10);
        cyc();

        // Branch while the response at 0x10 is outstanding.
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
        cyc();
        branch_taken = 1'b0;
        chk("drain_addr", imem_addr, 32'h10);
        chk("drain_valid", {31'b0, if_id_valid}, 32'h0);
        cyc();
        chk("drain_addr2", imem_addr, 32'h10);
        chk("drain_req", {31'b0, imem_req}, 32'h1);
        imem_ready = 1'b1;
        push_addr(32'h10);
        cyc();
        chk("drop_valid", {31'b0, if_id_valid}, 32'h0);
        chk("redirect_addr", imem_addr, 32'h100);
        push_addr(32'h100); push_load(32'hC0DE_0100, 32'h104);
        cyc();

        // Two branches in DRAIN: newest target wins.
        imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h300;
        cyc();
        branch_target = 32'h200;
        cyc();
        branch_taken = 1'b0; imem_ready = 1'b1;
        push_addr(32'h104);
        cyc();
        chk("newest_addr", imem_addr, 32'h200);
        push_addr(32'h200); push_load(32'hC0DE_0200, 32'h204);
        cyc();

        // Reset while HOLD has a full skid buffer.
        stall = 1'b1;
        push_addr(32'h204);
        cyc();
        chk("hold3_req", {31'b0, imem_req}, 32'h0);
        chk("hold3_instr", if_id_instr, 32'hC0DE_0200);
        reset = 1'b1;
        #1;
        chk("async_req", {31'b0, imem_req}, 32'h0);
        chk("async_instr", if_id_instr, 32'h0);
        chk("async_pc4", if_id_pc_plus4, 32'h0);
        chk("async_valid", {31'b0, if_id_valid}, 32'h0);
        cyc();
        stall = 1'b0; reset = 1'b0;
        chk("post_rst_addr", imem_addr, 32'h0);
        push_addr(32'h0); push_load(32'hC0DE_0000, 32'h4);
        cyc();
        imem_ready = 1'b0;
        cyc();
        cyc();
        chk("addr_q_empty", exp_addr.size(), 32'h0);
        chk("load_q_empty", exp_instr.size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
